// File: rtl/csa_accum_seq.sv
// csa_accum_seq: multi-operand accumulator. Operands fold into a redundant
// sum/carry pair through a 3:2 carry-save step, one per cycle; the last beat
// of a group triggers a single carry-propagate add and the W-bit result is
// offered on a valid/ready port.
// Optional build macro: CSA_ACCUM_OVF_EN adds a saturating beat counter and
// drives out_ovf when a group has more than 2^G beats (else out_ovf = 0).
module csa_accum_seq #(
    parameter  int N = 16,
    parameter  int G = 4,
    localparam int W = N + G
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_ovf
);

    typedef enum logic [1:0] {ACC, RES, OUT} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] s, c;
    logic [W-1:0] opx, maj;
    logic [W-1:0] s_nxt, c_nxt;
    logic         cin;
    logic         accept;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ACC;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs; in_ready depends on state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) state_nxt = RES;
            end
            RES: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    // Operand extension and 3:2 compression; subtract is ~op plus a carry-in
    // dropped into the free LSB of the shifted carry vector
    always_comb begin
        opx = W'(in_data);
        cin = 1'b0;
        if (in_sub) begin
            opx = ~opx;
            cin = 1'b1;
        end
        maj   = (s & c) | (s & opx) | (c & opx);
        s_nxt = s ^ c ^ opx;
        c_nxt = {maj[W-2:0], cin};
    end

    // Redundant accumulator and registered result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s       <= '0;
            c       <= '0;
            out_sum <= '0;
        end else begin
            if (accept) begin
                s <= s_nxt;
                c <= c_nxt;
            end
            if (state == RES) begin
                out_sum <= s + c;
                s       <= '0;
                c       <= '0;
            end
        end
    end

`ifdef CSA_ACCUM_OVF_EN
    localparam logic [G:0] CNT_SAT = (G+1)'((1 << G) + 1);
    localparam logic [G:0] CNT_LIM = (G+1)'(1 << G);

    logic [G:0] cnt;
    logic       ovf_q;

    // Saturating beat count; captured into out_ovf in RES and cleared there
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (state == RES) begin
            ovf_q <= (cnt > CNT_LIM);
            cnt   <= '0;
        end else if (accept && cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accum_seq.sv
// Self-checking bench for csa_accum_seq: directed groups from the test plan
// plus random groups, checked against a plain-arithmetic model of the sum.
module tb_csa_accum_seq;

    localparam int N = 16;
    localparam int G = 4;
    localparam int W = N + G;
`ifdef CSA_ACCUM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         in_sub = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_ovf;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_out_cyc = 0;

    logic [N-1:0] gd [64];
    bit           gs [64];

    csa_accum_seq #(.N(N), .G(G)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait (bounded) for in_ready, then report whether it came
    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 10) begin
            step();
            k++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Drive gd/gs[0..n-1] as one group; hold the result for 'stall' cycles
    // with junk beats offered, then hand it off.
    task automatic run_group(input int n, input int stall, input string tag);
        int unsigned acc = 0;
        logic [31:0] exp_sum;
        logic [31:0] exp_ovf;
        for (int i = 0; i < n; i++)
            acc = gs[i] ? acc - 32'(gd[i]) : acc + 32'(gd[i]);
        exp_sum = acc & ((32'd1 << W) - 1);
        exp_ovf = (OVF_EN && n > (1 << G)) ? 32'd1 : 32'd0;

        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = gd[i];
            in_sub   = gs[i];
            in_last  = (i == n - 1);
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_res_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_res_ready"}, {31'd0, in_ready}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, 32'(out_sum), exp_sum);
        check({tag, "_ovf"}, {31'd0, out_ovf}, exp_ovf);
        last_out_cyc = cyc;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            in_sub   = 1'($urandom);
            in_last  = 1'($urandom);
            step();
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_stall_sum"}, 32'(out_sum), exp_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int prev;
        // Reset
        reset_n = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_ovf", {31'd0, out_ovf}, 32'd0);
        reset_n = 1'b1;
        step();
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // Three max operands
        for (int i = 0; i < 3; i++) begin gd[i] = 16'hFFFF; gs[i] = 1'b0; end
        run_group(3, 0, "max3");
        check("max3_const", 32'(out_sum), 32'h2FFFD);

        // Add then subtract
        gd[0] = 16'd100; gs[0] = 1'b0;
        gd[1] = 16'd30;  gs[1] = 1'b1;
        run_group(2, 0, "addsub");

        // Single negative beat
        gd[0] = 16'd1; gs[0] = 1'b1;
        run_group(1, 0, "neg1");
        check("neg1_const", 32'(out_sum), 32'hFFFFF);

        // Guard capacity boundary: 16 and 17 beats
        for (int i = 0; i < 17; i++) begin gd[i] = 16'hFFFF; gs[i] = 1'b0; end
        run_group(16, 0, "b16");
        run_group(17, 0, "b17");

        // Output stall with beats offered, then an immediate next group
        gd[0] = 16'd100; gs[0] = 1'b0;
        gd[1] = 16'd30;  gs[1] = 1'b1;
        run_group(2, 5, "stall");
        gd[0] = 16'd7; gs[0] = 1'b0;
        run_group(1, 0, "after_stall");

        // Back-to-back single-beat groups, exactly 3 cycles apart
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            gd[0] = N'(3 + k); gs[0] = 1'b0;
            run_group(1, 0, "b2b");
            if (k > 0) check("b2b_spacing", 32'(last_out_cyc - prev), 32'd3);
            prev = last_out_cyc;
        end

        // Reset mid-group discards the partial sum
        in_valid = 1'b1; in_data = 16'd9; in_sub = 1'b0; in_last = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", 32'(out_sum), 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("midrst_idle", {31'd0, out_valid}, 32'd0);
        gd[0] = 16'd5; gs[0] = 1'b0;
        run_group(1, 0, "postrst");

        // Random groups
        for (int g = 0; g < 25; g++) begin
            int n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                gd[i] = N'($urandom);
                gs[i] = 1'($urandom);
            end
            run_group(n, int'($urandom_range(0, 3)), "rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/csa_accum_seq.md
# csa_accum_seq

Sequenced multi-operand accumulator built around the carry-save adder. It accepts a stream of N-bit operands, one per cycle, each marked add or subtract. Each operand is folded into a redundant sum/carry register pair with no carry propagation. On the last operand of a group, a single carry-propagate add resolves the pair and the W-bit result is presented on a valid/ready output port. It sits in front of the FPU/divider datapaths wherever several partial terms must be summed before one final add.

## Interface
- N, 16, operand width
- G, 4, guard bits; the group sum is G bits wider than an operand
- W, N+G, accumulator/result width (derived; not overridden)

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts beat this cycle
- in_data  in  N  operand, unsigned
- in_sub  in  1  1 = subtract this operand
- in_last  in  1  beat closes the group
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  W  group result, modulo 2^W
- out_ovf  out  1  group exceeded guard capacity (only with macro; else constant 0)

## Operation
- Beat accepted when in_valid && in_ready.
- Operand extension: opx = zero-extend(in_data) to W; if in_sub, opx = ~opx and cin = 1, else cin = 0.
- Per accepted beat, the 3:2 step is: S' = S ^ C ^ opx; C' = {majority(S,C,opx)[W-2:0], cin}.
  - The carry out of bit W-1 is discarded.
  - S' + C' = S + C + opx + cin (mod 2^W).
- States:
  - ACC: in_ready = 1. An accepted beat updates S,C. If in_last on that beat, go to RES.
  - RES: in_ready = 0. out_sum <= S + C (W-bit CPA); S,C <= 0. Go to OUT.
  - OUT: out_valid = 1, in_ready = 0. When out_ready, go to ACC; out_valid drops next cycle.
- Single-beat group (in_last on first beat): the result equals that operand (or its negation mod 2^W).
- in_sub/in_last are ignored when no beat is accepted.
- out_sum and out_ovf are registered and must hold stable while out_valid && !out_ready.

## Timing
- Reset (reset_n low at a clock edge): state=ACC, S=C=0, out_valid=0, out_sum=0, out_ovf=0, beat count=0. in_ready=1 from the first cycle after reset release.
- Reset mid-group or while in OUT: the partial group or pending result is discarded without output.
- Throughput: 1 beat/cycle within a group.
- Latency: last beat accepted in cycle t; out_valid=1 in cycle t+2.
- Earliest next beat: cycle after the out handshake. Minimum inter-group gap is 2 cycles (RES, OUT).
- No combinational path from in_valid to in_ready. in_ready depends only on state.

## Configuration
- CSA_ACCUM_OVF_EN defined:
  - A (G+1)-bit beat counter saturates at 2^G+1 and clears when entering RES.
  - out_ovf is registered in RES as 1 iff the group had more than 2^G beats.
- CSA_ACCUM_OVF_EN undefined:
  - No counter is built; out_ovf is tied to 0.
  - out_sum is identical in both builds.

## Test plan
- N=16,G=4: beats 0xFFFF, 0xFFFF, 0xFFFF(last), out_ready=1 -> out_valid at t+2, out_sum=0x2FFFD, out_ovf=0.
- Beats 100 (add), 30 (sub, last) -> out_sum=0x00046. Single beat 1 (sub, last) -> out_sum=0xFFFFF.
- Macro on, 17 beats of 0xFFFF -> out_sum=0x0FFEF, out_ovf=1. With 16 beats -> 0xFFFF0, out_ovf=0. Macro off, 17 beats -> same sum, out_ovf=0.
- out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, out_sum stable, no beat consumed. After handshake, the next beat (7, last) is accepted the following cycle -> out_sum=7.
- Back-to-back single-beat groups 3, 4, 5 with out_ready=1 -> results 3, 4, 5 in order, each exactly 3 cycles apart.
- reset_n low for 1 cycle after 2 accepted beats (9, 9) -> all outputs 0. New group 5(last) -> out_sum=5, with no stale 18 ever presented.
